// File: rtl/mem_req_adapter.sv
// Valid/ready front-end for a sync-read, byte-write RAM, with a 2-entry response buffer.
// Optional MEM_REQ_ADAPTER_STATS_EN adds rd_cnt/wr_cnt accepted-request counters.
module mem_req_adapter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AWIDTH-1:0]   req_addr,
    input  logic [DWIDTH/8-1:0] req_wbe,
    input  logic [DWIDTH-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DWIDTH-1:0]   resp_rdata,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic [DWIDTH-1:0]   mem_d,
    output logic [DWIDTH/8-1:0] mem_wbe,
    output logic                mem_en,
    input  logic [DWIDTH-1:0]   mem_q
`ifdef MEM_REQ_ADAPTER_STATS_EN
    ,
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt
`endif
);

    logic              pend;
    logic [DWIDTH-1:0] rbuf [2];
    logic              head;
    logic [1:0]        count;

    logic accept;
    logic is_rd;
    logic pop;
    logic pop_buf;
    logic push;
    logic tail;

    // Ready depends only on registered occupancy so it never loops back through resp_ready.
    assign req_ready  = rst_n && (({1'b0, count} + {2'b00, pend}) < 3'd2);
    assign accept     = req_valid && req_ready;
    assign is_rd      = (req_wbe == '0);

    assign resp_valid = rst_n && ((count != 2'd0) || pend);
    assign resp_rdata = (count != 2'd0) ? rbuf[head] : mem_q;

    assign pop     = resp_valid && resp_ready;
    assign pop_buf = pop && (count != 2'd0);
    assign push    = pend && !((count == 2'd0) && pop);
    assign tail    = head ^ (count == 2'd1);

    assign mem_addr = req_addr;
    assign mem_d    = req_wdata;
    assign mem_wbe  = accept ? req_wbe : '0;
    assign mem_en   = accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend  <= 1'b0;
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            pend <= accept && is_rd;
            if (push) begin
                rbuf[tail] <= mem_q;
            end
            if (pop_buf) begin
                head <= ~head;
            end
            case ({push, pop_buf})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef MEM_REQ_ADAPTER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (accept) begin
            if (is_rd) begin
                rd_cnt <= rd_cnt + 16'd1;
            end else begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_adapter.sv
// Directed bench for mem_req_adapter with a behavioural sync-read RAM and a read scoreboard.
// Honours MEM_REQ_ADAPTER_STATS_EN for the optional counter ports.
module tb_mem_req_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [3:0]  req_wbe;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_d;
    logic [3:0]  mem_wbe;
    logic        mem_en;
    logic [31:0] mem_q;
`ifdef MEM_REQ_ADAPTER_STATS_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    always #5 clk = ~clk;

    mem_req_adapter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wbe    (req_wbe),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_wbe    (mem_wbe),
        .mem_en     (mem_en),
        .mem_q      (mem_q)
`ifdef MEM_REQ_ADAPTER_STATS_EN
        ,
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
`endif
    );

    // Sync-read RAM: read data registered on a read enable, byte writes otherwise.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wbe[b]) ram[mem_addr][8*b +: 8] <= mem_d[8*b +: 8];
            end
            if (mem_wbe == 4'h0) mem_q <= ram[mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] a, input logic [3:0] w, input logic [31:0] d);
        req_valid = v;
        req_addr  = a;
        req_wbe   = w;
        req_wdata = d;
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (i >= 1 && i <= 3) ? 32'h11 * i : 32'h1000_0000 + i;
    endfunction

    logic [31:0] shadow [16];
    logic [31:0] q [$];
    int acc;
    int cyc;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] <= (i < 16) ? init_val(i) : 32'h0;
        mem_q <= 32'h0;
        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);

        // Reset with a request being offered
        rst_n = 1'b0;
        resp_ready = 1'b0;
        drive(1'b1, 12'h000, 4'h0, 32'h0);
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wbe", mem_wbe, 0);
        rst_n = 1'b1;
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_valid", resp_valid, 0);
        tick();

        // Full write then read-back
        resp_ready = 1'b1;
        drive(1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
        #1;
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_wbe", mem_wbe, 4'hF);
        check("wr_mem_addr", mem_addr, 12'h010);
        tick();
        drive(1'b1, 12'h010, 4'h0, 32'h0);
        #1;
        check("wr_no_resp", resp_valid, 0);
        check("rd_ready", req_ready, 1);
        tick();
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check("rd_valid", resp_valid, 1);
        check("rd_data_full", resp_rdata, 32'hDEADBEEF);
        tick();
        #1;
        check("rd_single_resp", resp_valid, 0);

        // Partial write then read-back
        drive(1'b1, 12'h010, 4'b0010, 32'h0000AB00);
        #1;
        check("pwr_mem_wbe", mem_wbe, 4'b0010);
        tick();
        drive(1'b1, 12'h010, 4'h0, 32'h0);
        #1;
        tick();
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check("prd_valid", resp_valid, 1);
        check("prd_data", resp_rdata, 32'hDEADABEF);
        tick();

        // Backpressure: two outstanding reads, third held
        resp_ready = 1'b0;
        drive(1'b1, 12'h001, 4'h0, 32'h0);
        #1;
        check("bp_ready0", req_ready, 1);
        tick();
        drive(1'b1, 12'h002, 4'h0, 32'h0);
        #1;
        check("bp_ready1", req_ready, 1);
        check("bp_valid1", resp_valid, 1);
        check("bp_data1", resp_rdata, 32'h11);
        tick();
        drive(1'b1, 12'h003, 4'h0, 32'h0);
        #1;
        check("bp_held_ready", req_ready, 0);
        check("bp_held_en", mem_en, 0);
        check("bp_data_hold", resp_rdata, 32'h11);
        tick();
        resp_ready = 1'b1;
        #1;
        check("bp_full_ready", req_ready, 0);
        check("bp_pop_11", resp_rdata, 32'h11);
        tick();
        #1;
        check("bp_ready_again", req_ready, 1);
        check("bp_pop_22", resp_rdata, 32'h22);
        tick();
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check("bp_valid_33", resp_valid, 1);
        check("bp_pop_33", resp_rdata, 32'h33);
        tick();
        #1;
        check("bp_drained", resp_valid, 0);

        // Back-to-back reads at full rate
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, 12'(i), 4'h0, 32'h0);
            else drive(1'b0, 12'h000, 4'h0, 32'h0);
            #1;
            if (i < 8) check("b2b_ready", req_ready, 1);
            if (i > 0) begin
                check("b2b_valid", resp_valid, 1);
                check("b2b_data", resp_rdata, init_val(i - 1));
            end
            tick();
        end
        #1;
        check("b2b_done", resp_valid, 0);

        // Random mixed traffic with random backpressure against the scoreboard
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            drive($urandom_range(3) != 0, 12'($urandom_range(15)),
                  ($urandom_range(1) != 0) ? 4'h0 : 4'($urandom_range(15)), $urandom);
            resp_ready = ($urandom_range(1) != 0);
            #1;
            check("rnd_ready", req_ready, q.size() < 2);
            check("rnd_valid", resp_valid, q.size() > 0);
            if (resp_valid && resp_ready && q.size() > 0) check("rnd_data", resp_rdata, q.pop_front());
            if (req_valid && req_ready) begin
                acc++;
                if (req_wbe == 4'h0) q.push_back(shadow[req_addr[3:0]]);
                else begin
                    for (int b = 0; b < 4; b++)
                        if (req_wbe[b]) shadow[req_addr[3:0]][8*b +: 8] = req_wdata[8*b +: 8];
                end
            end
            tick();
            cyc++;
        end
        if (acc < 1000) check("rnd_timeout", acc, 1000);
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (resp_valid) begin
                if (q.size() > 0) check("drain_data", resp_rdata, q.pop_front());
                else check("drain_extra", resp_valid, 0);
            end
            tick();
        end
        check("drain_empty", q.size(), 0);

        // Reset with one buffered and one in-flight read
        resp_ready = 1'b0;
        drive(1'b1, 12'h001, 4'h0, 32'h0);
        tick();
        drive(1'b1, 12'h002, 4'h0, 32'h0);
        tick();
        drive(1'b1, 12'h003, 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mrst_ready", req_ready, 0);
        check("mrst_valid", resp_valid, 0);
        check("mrst_mem_en", mem_en, 0);
        check("mrst_mem_wbe", mem_wbe, 0);
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check("mrel_valid", resp_valid, 0);
        check("mrel_ready", req_ready, 1);
`ifdef MEM_REQ_ADAPTER_STATS_EN
        check("mrel_rd_cnt", rd_cnt, 0);
        check("mrel_wr_cnt", wr_cnt, 0);
`endif
        tick();
        #1;
        check("mrel_no_stale", resp_valid, 0);
        drive(1'b1, 12'h005, 4'h0, 32'h0);
        #1;
        tick();
        drive(1'b0, 12'h000, 4'h0, 32'h0);
        #1;
        check("mrel_rd_valid", resp_valid, 1);
        check("mrel_rd_data", resp_rdata, shadow[5]);
`ifdef MEM_REQ_ADAPTER_STATS_EN
        check("mrel_rd_cnt1", rd_cnt, 1);
`endif
        tick();
        #1;
        check("mrel_idle", resp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
